// File: rtl/jt51_acc_seq_if.sv
// Purpose : Bundles the channel-config write port and the slot-sequence
//           outputs of jt51_acc_seq into one interface.
// Signals : cen            clock enable for the slot sequence
//           cfg_we/ch/rl/con  channel-config write (not gated by cen)
//           slot           current operator slot 0..31
//           m1/m2/c1/c2_enters  operator-group levels (one-hot)
//           op31_acc       high during slot 31
//           rl_I/con_I     config of the channel owning the current slot
//           sample         frame strobe (first M1 slot of a frame)
// Modports: master drives cen/cfg_* and observes the sequence; slave is the
//           sequencer itself.
interface jt51_acc_seq_if;
    logic       cen;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [1:0] cfg_rl;
    logic [2:0] cfg_con;

    logic [4:0] slot;
    logic       m1_enters;
    logic       m2_enters;
    logic       c1_enters;
    logic       c2_enters;
    logic       op31_acc;
    logic [1:0] rl_I;
    logic [2:0] con_I;
    logic       sample;

    modport master (
        output cen, cfg_we, cfg_ch, cfg_rl, cfg_con,
        input  slot, m1_enters, m2_enters, c1_enters, c2_enters,
        input  op31_acc, rl_I, con_I, sample
    );

    modport slave (
        input  cen, cfg_we, cfg_ch, cfg_rl, cfg_con,
        output slot, m1_enters, m2_enters, c1_enters, c2_enters,
        output op31_acc, rl_I, con_I, sample
    );
endinterface

// File: rtl/jt51_acc_seq.sv
// Purpose : Operator-slot sequencer for the JT51 accumulator. A 5-bit slot
//           counter advances on cen; the group flags, op31/sample strobes and
//           the owning channel's {rl,con} are all registered alongside slot so
//           they change on the same edge. An 8-entry {rl,con} table is written
//           through the cfg port independently of cen.
// Ports   : clk   single clock, rising edge
//           rst   synchronous active-high reset
//           sync  (only with JT51_ACC_SEQ_SYNC_EN) restart frame at slot 0
//           bus   jt51_acc_seq_if.slave (cen, cfg_*, sequence outputs)
// Option  : define JT51_ACC_SEQ_SYNC_EN to add the sync input; without it the
//           counter runs free.
module jt51_acc_seq (
    input  logic clk,
    input  logic rst,
`ifdef JT51_ACC_SEQ_SYNC_EN
    input  logic sync,
`endif
    jt51_acc_seq_if.slave bus
);

    localparam int unsigned SLOT_W = 5;
    localparam int unsigned CH_N   = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned RL_W   = 2;
    localparam int unsigned CON_W  = 3;
    localparam int unsigned ENT_W  = RL_W + CON_W;
    localparam int unsigned GRP_N  = 4;

    logic [SLOT_W-1:0] slot_q,   slot_d;
    logic [GRP_N-1:0]  grp_q,    grp_d;      // one-hot {c2,c1,m2,m1}
    logic              op31_q,   op31_d;
    logic              sample_q, sample_d;
    logic [RL_W-1:0]   rl_q,     rl_d;
    logic [CON_W-1:0]  con_q,    con_d;
    logic [ENT_W-1:0]  tbl_q [CH_N];
    logic [ENT_W-1:0]  tbl_d [CH_N];

    logic [SLOT_W-1:0] slot_nxt_c;
    logic [CH_W-1:0]   ch_nxt_c;
    logic [ENT_W-1:0]  ent_c;

    // Next-state: everything is computed from the slot being entered so the
    // registered outputs always describe the slot register they sit beside.
    always_comb begin
        slot_nxt_c = slot_q + SLOT_W'(1);
`ifdef JT51_ACC_SEQ_SYNC_EN
        if (sync) begin
            slot_nxt_c = '0;
        end
`endif
        ch_nxt_c = slot_nxt_c[CH_W-1:0];

        tbl_d = tbl_q;
        if (bus.cfg_we) begin
            tbl_d[bus.cfg_ch] = {bus.cfg_rl, bus.cfg_con};
        end

        // A write landing on the channel being loaded wins over the stale entry.
        if (bus.cfg_we && (bus.cfg_ch == ch_nxt_c)) begin
            ent_c = {bus.cfg_rl, bus.cfg_con};
        end else begin
            ent_c = tbl_q[ch_nxt_c];
        end

        slot_d   = slot_q;
        grp_d    = grp_q;
        op31_d   = op31_q;
        sample_d = sample_q;
        rl_d     = rl_q;
        con_d    = con_q;
        if (bus.cen) begin
            slot_d        = slot_nxt_c;
            grp_d         = GRP_N'(4'b0001 << slot_nxt_c[SLOT_W-1:SLOT_W-2]);
            op31_d        = &slot_nxt_c;
            sample_d      = (slot_nxt_c == '0);
            {rl_d, con_d} = ent_c;
        end
    end

    // State registers; reset also clears the config table and blocks writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            grp_q    <= GRP_N'(4'b0001);
            op31_q   <= 1'b0;
            sample_q <= 1'b0;
            rl_q     <= '0;
            con_q    <= '0;
            for (int i = 0; i < int'(CH_N); i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            slot_q   <= slot_d;
            grp_q    <= grp_d;
            op31_q   <= op31_d;
            sample_q <= sample_d;
            rl_q     <= rl_d;
            con_q    <= con_d;
            for (int i = 0; i < int'(CH_N); i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign bus.slot      = slot_q;
    assign bus.m1_enters = grp_q[0];
    assign bus.m2_enters = grp_q[1];
    assign bus.c1_enters = grp_q[2];
    assign bus.c2_enters = grp_q[3];
    assign bus.op31_acc  = op31_q;
    assign bus.sample    = sample_q;
    assign bus.rl_I      = rl_q;
    assign bus.con_I     = con_q;

endmodule

// File: tb/tb_jt51_acc_seq.sv
// Purpose : Self-checking bench for jt51_acc_seq. Directed scenarios compare
//           against constants; the random scenario compares against a
//           slot/table model kept in plain integers and arrays.
module tb_jt51_acc_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef JT51_ACC_SEQ_SYNC_EN
    logic sync = 1'b0;
`endif

    always #5 clk = ~clk;

    jt51_acc_seq_if bus();

    jt51_acc_seq u_dut (
        .clk  (clk),
        .rst  (rst),
`ifdef JT51_ACC_SEQ_SYNC_EN
        .sync (sync),
`endif
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int         m_slot;
    logic [4:0] m_tbl [8];
    logic [1:0] m_rl;
    logic [2:0] m_con;
    logic       m_sample;

    // Model of one clock edge, using the inputs presented before the edge.
    task automatic model_edge();
        int  ns;
        logic sy;
        sy = 1'b0;
`ifdef JT51_ACC_SEQ_SYNC_EN
        sy = sync;
`endif
        if (rst) begin
            m_slot = 0; m_rl = '0; m_con = '0; m_sample = 1'b0;
            for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        end else begin
            if (bus.cen) begin
                ns = sy ? 0 : (m_slot + 1) % 32;
                m_slot   = ns;
                m_sample = (ns == 0);
                if (bus.cfg_we && (int'(bus.cfg_ch) == ns % 8))
                    {m_rl, m_con} = {bus.cfg_rl, bus.cfg_con};
                else
                    {m_rl, m_con} = m_tbl[ns % 8];
            end
            if (bus.cfg_we) m_tbl[bus.cfg_ch] = {bus.cfg_rl, bus.cfg_con};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [15:0] exp_vec();
        int g;
        g = m_slot / 8;
        return {5'(m_slot), g == 3, g == 2, g == 1, g == 0, m_slot == 31,
                m_sample, m_rl, m_con};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.slot, bus.c2_enters, bus.c1_enters, bus.m2_enters,
                bus.m1_enters, bus.op31_acc, bus.sample, bus.rl_I, bus.con_I};
    endfunction

    localparam logic [15:0] RESET_VEC = {5'd0, 4'b0001, 1'b0, 1'b0, 2'd0, 3'd0};

    task automatic drive(input logic c, input logic we, input logic [2:0] ch,
                         input logic [1:0] rl, input logic [2:0] con);
        bus.cen = c; bus.cfg_we = we; bus.cfg_ch = ch;
        bus.cfg_rl = rl; bus.cfg_con = con;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
        repeat (3) step();
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset got=%h exp=%h", dut_vec(), RESET_VEC);
            miscompares++;
        end
        // cfg writes and cen are ignored while reset is held
        drive(1'b1, 1'b1, 3'd0, 2'd3, 3'd7);
        step();
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset_we got=%h exp=%h", dut_vec(), RESET_VEC);
            miscompares++;
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
        step();
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset_release got=%h exp=%h", dut_vec(), RESET_VEC);
            miscompares++;
        end
    endtask

    task automatic test_free_run();
        logic [15:0] e;
        int s;
        bus.cen = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            s = k % 32;
            e = {5'(s), s >= 24, (s >= 16 && s < 24), (s >= 8 && s < 16), s < 8,
                 s == 31, k == 32, 2'd0, 3'd0};
            vectors++;
            if (dut_vec() !== e) begin
                $display("FAIL free_run k=%0d got=%h exp=%h", k, dut_vec(), e);
                miscompares++;
            end
        end
    endtask

    task automatic test_cfg_ch5();
        logic [9:0] e;
        int s;
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b0, 1'b1, 3'd5, 2'b10, 3'd7);
        step();
        drive(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 32; k++) begin
            step();
            s = k % 32;
            e = (s % 8 == 5) ? {5'(s), 2'b10, 3'd7} : {5'(s), 2'b00, 3'd0};
            vectors++;
            if ({bus.slot, bus.rl_I, bus.con_I} !== e) begin
                $display("FAIL cfg_ch5 k=%0d got=%h exp=%h", k,
                         {bus.slot, bus.rl_I, bus.con_I}, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_bypass();
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        step(); step();
        vectors++;
        if (bus.slot !== 5'd2) begin
            $display("FAIL bypass_pre got=%0d exp=2", bus.slot);
            miscompares++;
        end
        drive(1'b1, 1'b1, 3'd3, 2'd1, 3'd4);
        step();
        vectors++;
        if ({bus.slot, bus.rl_I, bus.con_I} !== {5'd3, 2'd1, 3'd4}) begin
            $display("FAIL bypass got=%h exp=%h", {bus.slot, bus.rl_I, bus.con_I},
                     {5'd3, 2'd1, 3'd4});
            miscompares++;
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_cen_toggle();
        int cnt;
        int e;
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
        cnt = 0;
        for (int i = 0; i < 66; i++) begin
            bus.cen = (i % 2 == 0);
            step();
            e = (i / 2 + 1) % 32;
            if (bus.sample === 1'b1) cnt++;
            vectors++;
            if (bus.slot !== 5'(e)) begin
                $display("FAIL cen_toggle i=%0d got=%0d exp=%0d", i, bus.slot, e);
                miscompares++;
            end
        end
        vectors++;
        if (cnt != 2) begin
            $display("FAIL sample_width got=%0d exp=2", cnt);
            miscompares++;
        end
        // slot is 1 here; write channel 1 with cen=0 must not disturb con_I
        drive(1'b0, 1'b1, 3'd1, 2'd3, 3'd5);
        step();
        vectors++;
        if ({bus.slot, bus.rl_I, bus.con_I} !== {5'd1, 2'd0, 3'd0}) begin
            $display("FAIL cen0_write got=%h exp=%h", {bus.slot, bus.rl_I, bus.con_I},
                     {5'd1, 2'd0, 3'd0});
            miscompares++;
        end
        drive(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        repeat (8) step();
        vectors++;
        if ({bus.slot, bus.rl_I, bus.con_I} !== {5'd9, 2'd3, 3'd5}) begin
            $display("FAIL cen0_write_later got=%h exp=%h",
                     {bus.slot, bus.rl_I, bus.con_I}, {5'd9, 2'd3, 3'd5});
            miscompares++;
        end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 3'(i), 2'(i % 3 + 1), 3'(7 - i));
            step();
        end
        drive(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        repeat (20) step();
        vectors++;
        if ({bus.slot, bus.rl_I, bus.con_I} !== {5'd20, 2'd2, 3'd3}) begin
            $display("FAIL rst_mid_pre got=%h exp=%h", {bus.slot, bus.rl_I, bus.con_I},
                     {5'd20, 2'd2, 3'd3});
            miscompares++;
        end
        rst = 1'b1;
        step();
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL rst_mid got=%h exp=%h", dut_vec(), RESET_VEC);
            miscompares++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if ({bus.slot, bus.rl_I, bus.con_I} !== {5'(k), 2'd0, 3'd0}) begin
                $display("FAIL rst_tbl k=%0d got=%h exp=%h", k,
                         {bus.slot, bus.rl_I, bus.con_I}, {5'(k), 2'd0, 3'd0});
                miscompares++;
            end
        end
    endtask

`ifdef JT51_ACC_SEQ_SYNC_EN
    task automatic test_sync();
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        repeat (17) step();
        sync = 1'b1; bus.cen = 1'b0;
        step();
        vectors++;
        if (bus.slot !== 5'd17) begin
            $display("FAIL sync_cen0 got=%0d exp=17", bus.slot);
            miscompares++;
        end
        bus.cen = 1'b1;
        step();
        sync = 1'b0;
        vectors++;
        if ({bus.slot, bus.sample, bus.m1_enters} !== {5'd0, 1'b1, 1'b1}) begin
            $display("FAIL sync got=%h exp=%h", {bus.slot, bus.sample, bus.m1_enters},
                     {5'd0, 1'b1, 1'b1});
            miscompares++;
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
`ifdef JT51_ACC_SEQ_SYNC_EN
            sync = ($urandom_range(0, 15) == 0);
`endif
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)));
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
                miscompares++;
            end
        end
        rst = 1'b0;
`ifdef JT51_ACC_SEQ_SYNC_EN
        sync = 1'b0;
`endif
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 2'd0, 3'd0);
        test_reset();
        test_free_run();
        test_cfg_ch5();
        test_bypass();
        test_cen_toggle();
        test_rst_mid();
`ifdef JT51_ACC_SEQ_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
